a2d_spi_resp: RTL and testbench

SPI responder for the A2D link: the slave end of the 16-bit SPI transactions the A2D interface issues on `A2D_SS_n`/`A2D_SCLK`/`A2D_MOSI`, returning 12-bit conversion results on `A2D_MISO`. It is a synthesizable, clk-domain model of the converter that runs on the FPGA for loopback and fullchip benches. It decodes the channel address from each command frame and returns that channel's sample in the following frame, giving a one-frame pipeline.

---
 rtl/a2d_spi_resp.sv | 81 ++++++++
 tb/tb_a2d_spi_resp.sv | 122 ++++++++++++
 2 files changed

// File: rtl/a2d_spi_resp.sv
// a2d_spi_resp: clk-domain SPI slave model of the A2D converter.
// Decodes the channel from each 16-bit command frame and returns that channel's sample in the next frame.
module a2d_spi_resp #(
  parameter int FRM_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic [2:0]  chnl,
  input  logic [11:0] smpl_data,
  output logic        frm_done,
  output logic        frm_err
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  localparam logic [4:0] CNT_FRM = 5'(FRM_BITS);
  localparam logic [4:0] CNT_MAX = 5'(FRM_BITS + 1);
  state_t      state, nxt;
  logic [2:0]  ss_sync, sclk_sync;
  logic [1:0]  mosi_sync;
  logic        vld, armed;
  logic [15:0] tx_shft;
  logic [13:0] rx_shft;
  logic [4:0]  bit_cnt;
  logic        ss_fall, ss_rise, sclk_rise, sclk_fall, go, fin, good;
  assign ss_fall   = ss_sync[2] & ~ss_sync[1];
  assign ss_rise   = ~ss_sync[2] & ss_sync[1];
  assign sclk_rise = ~sclk_sync[2] & sclk_sync[1];
  assign sclk_fall = sclk_sync[2] & ~sclk_sync[1];
  assign good      = bit_cnt == CNT_FRM;
  assign MISO      = (state == ACTIVE) & tx_shft[15];
  // armed blocks a frame already in progress at reset release: SS_n must first be sampled high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ss_sync   <= 3'b111;
      sclk_sync <= 3'b111;
      mosi_sync <= 2'b00;
      vld       <= 1'b0;
      armed     <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[1:0], SS_n};
      sclk_sync <= {sclk_sync[1:0], SCLK};
      mosi_sync <= {mosi_sync[0], MOSI};
      vld       <= 1'b1;
      armed     <= armed | (vld & ss_sync[0]);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = (state == IDLE) ? ((ss_fall && armed) ? ACTIVE : IDLE) : (ss_rise ? IDLE : ACTIVE);
    go  = (state == IDLE) && ss_fall && armed;
    fin = (state == ACTIVE) && ss_rise;
  end
  // an SS_n rise on the same clk as an SCLK edge drops the edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_shft  <= '0;
      rx_shft  <= '0;
      bit_cnt  <= '0;
      chnl     <= '0;
      frm_done <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      frm_done <= fin && good;
      frm_err  <= fin && !good;
      if (fin && good) chnl <= rx_shft[13:11];
      if (go) begin
        tx_shft <= {4'b0000, smpl_data};
        bit_cnt <= '0;
      end else if (state == ACTIVE && !ss_rise) begin
        if (sclk_rise) begin
          rx_shft <= {rx_shft[12:0], mosi_sync[1]};
          if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 5'd1;
        end
        if (sclk_fall && bit_cnt != 5'd0) tx_shft <= {tx_shft[14:0], 1'b0};
      end
    end
endmodule

// File: tb/tb_a2d_spi_resp.sv
// tb_a2d_spi_resp: directed SPI master frames; a monitor checks each frame-end pulse against a queue.
module tb_a2d_spi_resp;
  typedef struct {
    logic        done;
    logic [2:0]  ch;
    logic [15:0] word;
    logic        chk;
  } exp_t;
  logic        clk = 1'b0, rst_n = 1'b0, SS_n = 1'b1, SCLK = 1'b0, MOSI = 1'b0;
  logic        MISO, frm_done, frm_err, use_chnl = 1'b0;
  logic [2:0]  chnl;
  logic [11:0] fixed = 12'hA5C, smpl_data;
  logic [15:0] got = '0;
  exp_t        exp_q[$];
  int          checks = 0, errors = 0;
  assign smpl_data = use_chnl ? {9'h0, chnl} : fixed;
  a2d_spi_resp dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .chnl(chnl), .smpl_data(smpl_data), .frm_done(frm_done), .frm_err(frm_err)
  );
  always #5 clk = ~clk;
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic start(input logic hi);
    SCLK = hi;
    idle(4);
    got = '0;
    SS_n = 1'b0;
    idle(6);
  endtask
  task automatic bits(input logic [15:0] cmd, input int n);
    for (int i = 0; i < n; i++) begin
      SCLK = 1'b0;
      MOSI = cmd[15 - (i % 16)];
      idle(6);
      got = {got[14:0], MISO};
      SCLK = 1'b1;
      idle(6);
    end
  endtask
  task automatic stop(input logic hi);
    if (!hi) begin
      SCLK = 1'b0;
      idle(6);
    end
    SS_n = 1'b1;
    idle(8);
  endtask
  task automatic frame(input logic [15:0] cmd, input int n, input logic hi,
                       input logic done, input logic [2:0] ch, input logic [15:0] word, input logic wchk);
    exp_t e;
    e.done = done; e.ch = ch; e.word = word; e.chk = wchk;
    exp_q.push_back(e);
    start(hi);
    bits(cmd, n);
    stop(hi);
  endtask
  initial forever begin
    @(negedge clk);
    if (frm_done || frm_err) begin
      if (exp_q.size() == 0) chk("unexpected_pulse", {frm_done, frm_err}, 2'b00);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_kind", {frm_done, frm_err}, {e.done, ~e.done});
        chk("chnl", chnl, e.ch);
        if (e.chk) chk("miso_word", got, e.word);
        @(negedge clk);
        chk("pulse_width", {frm_done, frm_err}, 2'b00);
      end
    end
  end
  initial begin
    idle(2);
    chk("rst_miso", MISO, 0);
    chk("rst_chnl", chnl, 0);
    chk("rst_done", frm_done, 0);
    chk("rst_err", frm_err, 0);
    rst_n = 1'b1;
    idle(4);
    frame(16'h2800, 16, 1'b0, 1'b1, 3'd5, 16'h0A5C, 1'b1);
    use_chnl = 1'b1;
    frame(16'h1800, 16, 1'b0, 1'b1, 3'd3, 16'h0005, 1'b1);
    frame(16'h3000, 16, 1'b0, 1'b1, 3'd6, 16'h0003, 1'b1);
    frame(16'h1000, 16, 1'b0, 1'b1, 3'd2, 16'h0006, 1'b1);
    frame(16'h3800, 9, 1'b0, 1'b0, 3'd2, 16'h0000, 1'b0);
    frame(16'h0800, 16, 1'b0, 1'b1, 3'd1, 16'h0002, 1'b1);
    frame(16'h2000, 17, 1'b0, 1'b0, 3'd1, 16'h0000, 1'b0);
    use_chnl = 1'b0;
    fixed = 12'hFFF;
    frame(16'h0000, 16, 1'b1, 1'b1, 3'd0, 16'h0FFF, 1'b1);
    frame(16'h0000, 16, 1'b0, 1'b1, 3'd0, 16'h0FFF, 1'b1);
    frame(16'h2800, 16, 1'b0, 1'b1, 3'd5, 16'h0FFF, 1'b1);
    start(1'b0);
    bits(16'h1800, 8);
    rst_n = 1'b0;
    #1;
    chk("abort_miso", MISO, 0);
    chk("abort_chnl", chnl, 0);
    idle(3);
    rst_n = 1'b1;
    idle(12);
    chk("abort_no_pulse_pending", exp_q.size(), 0);
    SCLK = 1'b0;
    SS_n = 1'b1;
    idle(10);
    fixed = 12'hA5C;
    frame(16'h1800, 16, 1'b0, 1'b1, 3'd3, 16'h0A5C, 1'b1);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) idle(1);
    if (exp_q.size() != 0) chk("pulse_timeout", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
